// File: rtl/dmem_pkg.sv
// Data memory controller shared types.
// Size codes, FSM states and byte-lane helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int LANES = 4;

  function automatic logic [3:0] lane_en(
    input size_e      sz,
    input logic [1:0] off
  );
    case (sz)
      SZ_B:    lane_en = 4'b0001 << off;
      SZ_H:    lane_en = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  endfunction

  // Low address bits kept for a given size.
  function automatic logic [1:0] off_mask(
    input size_e sz
  );
    case (sz)
      SZ_H:    off_mask = 2'b10;
      SZ_W:    off_mask = 2'b00;
      default: off_mask = 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte lane of data memory.
// Synchronous read register holds until the next read.
module dmem_bank #(
  parameter int DEPTH = 65536,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [IW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-lane data memory controller, valid/ready request, pulse response.
// Optional DMEM_ALIGN_TRAP_EN: misaligned half/word raise rsp_err.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 65536,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IW = $clog2(DEPTH_WORDS);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;

  logic          we_q, we_d;
  size_e         sz_q, sz_d;
  logic          sgn_q, sgn_d;
  logic [1:0]    off_q, off_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;

  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_ld_q, rsp_ld_d;
  size_e         rsp_sz_q, rsp_sz_d;
  logic          rsp_sgn_q, rsp_sgn_d;
  logic [1:0]    rsp_off_q, rsp_off_d;

  size_e         in_sz;
  logic          in_mis;
  logic          in_err;
  logic          accept;
  logic          access;
  logic [3:0]    bank_we;
  logic          bank_re;
  logic [31:0]   st_word;
  logic [7:0]    bq [LANES];
  logic [31:0]   rword;
  logic [31:0]   shw;
  logic [31:0]   ext;
  logic          unused_addr;

  assign unused_addr = ^req_addr;

  assign req_ready = ((state_q == ST_IDLE) ||
                      (state_q == ST_RESP)) && !rst;
  assign accept    = req_valid && req_ready;
  assign access    = (state_q == ST_BUSY) && (cnt_q == 3'd0);

  // Decode size and alignment of the incoming request
  always_comb begin
    in_sz  = size_e'(req_size);
    in_mis = ((in_sz == SZ_H) && req_addr[0]) ||
             ((in_sz == SZ_W) && (req_addr[1:0] != 2'b00));
`ifdef DMEM_ALIGN_TRAP_EN
    in_err = (in_sz == SZ_RSV) || in_mis;
`else
    in_err = (in_sz == SZ_RSV);
`endif
  end

  // Next state, request capture and response formatting
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    sz_d        = sz_q;
    sgn_d       = sgn_q;
    off_d       = off_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_ld_d    = rsp_ld_q;
    rsp_sz_d    = rsp_sz_q;
    rsp_sgn_d   = rsp_sgn_q;
    rsp_off_d   = rsp_off_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          state_d = ST_BUSY;
          cnt_d   = 3'(WAIT_STATES);
          we_d    = req_we;
          sz_d    = in_sz;
          sgn_d   = req_signed;
          off_d   = req_addr[1:0] & off_mask(in_sz);
          idx_d   = req_addr[IW+1:2];
          wdata_d = req_wdata;
          err_d   = in_err;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 3'd0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          rsp_ld_d    = !we_q && !err_q;
          rsp_sz_d    = sz_q;
          rsp_sgn_d   = sgn_q;
          rsp_off_d   = off_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_ld_q    <= 1'b0;
      rsp_sz_q    <= SZ_W;
      rsp_sgn_q   <= 1'b0;
      rsp_off_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_ld_q    <= rsp_ld_d;
      rsp_sz_q    <= rsp_sz_d;
      rsp_sgn_q   <= rsp_sgn_d;
      rsp_off_q   <= rsp_off_d;
    end
  end

  // Captured request fields, no reset needed
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    sz_q    <= sz_d;
    sgn_q   <= sgn_d;
    off_q   <= off_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    err_q   <= err_d;
  end

  // Replicate store data across lanes and gate the bank strobes
  always_comb begin
    case (sz_q)
      SZ_B:    st_word = {4{wdata_q[7:0]}};
      SZ_H:    st_word = {2{wdata_q[15:0]}};
      default: st_word = wdata_q;
    endcase
    bank_we = (access && we_q && !err_q && !rst) ?
              lane_en(sz_q, off_q) : 4'b0000;
    bank_re = access && !we_q && !err_q && !rst;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_bank
    dmem_bank #(
      .DEPTH (DEPTH_WORDS)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[g]),
      .re    (bank_re),
      .addr  (idx_q),
      .wdata (st_word[8*g+:8]),
      .rdata (bq[g])
    );
  end

  // Extract and extend load data from the held bank outputs
  always_comb begin
    rword = {bq[3], bq[2], bq[1], bq[0]};
    shw   = rword >> {rsp_off_q, 3'b000};
    case (rsp_sz_q)
      SZ_B:    ext = {{24{rsp_sgn_q & shw[7]}}, shw[7:0]};
      SZ_H:    ext = {{16{rsp_sgn_q & shw[15]}}, shw[15:0]};
      SZ_W:    ext = rword;
      default: ext = 32'd0;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_ld_q ? ext : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: WAIT_STATES=0/DEPTH 1024 and WAIT_STATES=3.
// Expectations follow DMEM_ALIGN_TRAP_EN when defined.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic        a_valid, a_ready, a_we, a_sgn, a_rv, a_err;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata, a_rdata;

  logic        b_valid, b_ready, b_we, b_sgn, b_rv, b_err;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata, b_rdata;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  dmem_ctrl #(
    .ADDR_W      (32),
    .DEPTH_WORDS (1024),
    .WAIT_STATES (0)
  ) u_a (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (a_valid),
    .req_ready  (a_ready),
    .req_we     (a_we),
    .req_size   (a_size),
    .req_signed (a_sgn),
    .req_addr   (a_addr),
    .req_wdata  (a_wdata),
    .rsp_valid  (a_rv),
    .rsp_rdata  (a_rdata),
    .rsp_err    (a_err)
  );

  dmem_ctrl #(
    .WAIT_STATES (3)
  ) u_b (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (b_valid),
    .req_ready  (b_ready),
    .req_we     (b_we),
    .req_size   (b_size),
    .req_signed (b_sgn),
    .req_addr   (b_addr),
    .req_wdata  (b_wdata),
    .rsp_valid  (b_rv),
    .rsp_rdata  (b_rdata),
    .rsp_err    (b_err)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(
    input string       tag,
    input logic        we,
    input logic [1:0]  sz,
    input logic        sg,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [31:0] exp_rd,
    input logic        exp_err
  );
    int          n;
    int          lat;
    logic [31:0] rd;
    logic        e;
    @(negedge clk);
    a_valid = 1'b1;
    a_we    = we;
    a_size  = sz;
    a_sgn   = sg;
    a_addr  = addr;
    a_wdata = wd;
    n = 0;
    while (!a_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 a_valid = 1'b0;
    lat = 0;
    rd  = 32'd0;
    e   = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (a_rv) begin
        lat = i;
        rd  = a_rdata;
        e   = a_err;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_rd"}, rd, exp_rd);
    chk({tag, "_err"}, e, exp_err);
  endtask

  logic [11:0] rdy, rvv;
  logic [31:0] rd10;
  int          acc0, acc1, nacc;
  logic        seen;

  initial begin
    rst = 1'b1;
    a_valid = 0; a_we = 0; a_size = 0; a_sgn = 0;
    a_addr = 0; a_wdata = 0;
    b_valid = 0; b_we = 0; b_size = 0; b_sgn = 0;
    b_addr = 0; b_wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rv", a_rv, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_err", a_err, 0);
    chk("idle_ready", a_ready, 1);

    run("sw10", 1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 0);
    run("lw10", 0, 2'b10, 0, 32'h10, 0, 32'h11223344, 0);
    run("sb12", 1, 2'b00, 0, 32'h12, 32'h000000AB, 32'h0, 0);
    run("lb12", 0, 2'b00, 1, 32'h12, 0, 32'hFFFFFFAB, 0);
    run("lbu12", 0, 2'b00, 0, 32'h12, 0, 32'h000000AB, 0);
    run("lw10b", 0, 2'b10, 0, 32'h10, 0, 32'h11AB3344, 0);

    run("sw14", 1, 2'b10, 0, 32'h14, 32'h12348001, 32'h0, 0);
    run("sh16", 1, 2'b01, 0, 32'h16, 32'h00008001, 32'h0, 0);
    run("lh16", 0, 2'b01, 1, 32'h16, 0, 32'hFFFF8001, 0);
    run("lhu16", 0, 2'b01, 0, 32'h16, 0, 32'h00008001, 0);
`ifdef DMEM_ALIGN_TRAP_EN
    run("lh15", 0, 2'b01, 1, 32'h15, 0, 32'h0, 1);
    run("sh15", 1, 2'b01, 0, 32'h15, 32'h7777, 32'h0, 1);
    run("lw14", 0, 2'b10, 0, 32'h14, 0, 32'h80018001, 0);
    run("lw13", 0, 2'b10, 0, 32'h13, 0, 32'h0, 1);
`else
    run("lh15", 0, 2'b01, 1, 32'h15, 0, 32'hFFFF8001, 0);
    run("sh15", 1, 2'b01, 0, 32'h15, 32'h7777, 32'h0, 0);
    run("lw14", 0, 2'b10, 0, 32'h14, 0, 32'h80017777, 0);
    run("lw13", 0, 2'b10, 0, 32'h13, 0, 32'h11AB3344, 0);
`endif

    run("rsv_st", 1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, 32'h0, 1);
    run("lw10c", 0, 2'b10, 0, 32'h10, 0, 32'h11AB3344, 0);
    run("rsv_ld", 0, 2'b11, 1, 32'h10, 0, 32'h0, 1);

    run("sw1000", 1, 2'b10, 0, 32'h1000, 32'hDEADBEEF, 32'h0, 0);
    run("lw0", 0, 2'b10, 0, 32'h0, 0, 32'hDEADBEEF, 0);
    run("lw10d", 0, 2'b10, 0, 32'h10, 0, 32'h11AB3344, 0);

    run("sw20", 1, 2'b10, 0, 32'h20, 32'h00000099, 32'h0, 0);
    run("lw20", 0, 2'b10, 0, 32'h20, 0, 32'h00000099, 0);
    repeat (3) @(negedge clk);
    chk("hold_rdata", a_rdata, 32'h00000099);
    chk("hold_rv", a_rv, 0);

    // reset lands on the commit edge of SW 0x5 @0x20
    @(negedge clk);
    a_valid = 1'b1; a_we = 1'b1; a_size = 2'b10;
    a_sgn = 1'b0; a_addr = 32'h20; a_wdata = 32'h5;
    chk("rc_ready0", a_ready, 1);
    @(posedge clk);
    #1 a_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rc_ready_rst", a_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (a_rv) seen = 1'b1;
    end
    chk("rc_no_rsp", seen, 0);
    chk("rc_rdata", a_rdata, 0);
    chk("rc_err", a_err, 0);
    run("lw20r", 0, 2'b10, 0, 32'h20, 0, 32'h00000099, 0);

    // back-to-back requests with WAIT_STATES=3
    acc0 = -1; acc1 = -1; nacc = 0;
    rdy = '0; rvv = '0; rd10 = '0;
    @(negedge clk);
    b_valid = 1'b1; b_we = 1'b1; b_size = 2'b10;
    b_addr = 32'h40; b_wdata = 32'hCAFE0001;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      rdy[c] = b_ready;
      rvv[c] = b_rv;
      if (c == 10) rd10 = b_rdata;
      @(posedge clk);
      if (b_valid && rdy[c]) begin
        if (nacc == 0) acc0 = c;
        else acc1 = c;
        nacc++;
      end
      #1;
      if (nacc == 1) b_we = 1'b0;
      if (nacc == 2) b_valid = 1'b0;
    end
    chk("ws3_acc0", acc0, 0);
    chk("ws3_acc1", acc1, 5);
    chk("ws3_ready", {20'd0, rdy}, 32'h00000C21);
    chk("ws3_rvalid", {20'd0, rvv}, 32'h00000420);
    chk("ws3_rdata", rd10, 32'hCAFE0001);
    chk("ws3_err", b_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 65536, power of two, number of 32-bit words.
REQ-003 SHALL have parameter WAIT_STATES, default 0, range 0..7, extra busy cycles per access.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  request accepted this edge when both high.
REQ-008 SHALL have port req_we  in  1  1=store, 0=load.
REQ-009 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-010 SHALL have port req_signed  in  1  load sign-extend (1) or zero-extend (0).
REQ-011 SHALL have port req_addr  in  ADDR_W  byte address.
REQ-012 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-013 SHALL have port rsp_valid  out  1  one-cycle completion pulse, loads and stores.
REQ-014 SHALL have port rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  out  1  access rejected, valid with rsp_valid.

Function
REQ-016 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; RESP -> BUSY when a new request is accepted in RESP.
REQ-017 SHALL drive req_ready high in IDLE and RESP only; request fields captured on the accepting edge.
REQ-018 SHALL stay in BUSY for exactly WAIT_STATES+1 cycles, using a down-counter loaded on accept.
REQ-019 SHALL perform the memory access (store commit / load read) on the last BUSY edge, and assert rsp_valid in the following cycle: request in cycle 0, response in cycle WAIT_STATES+2.
REQ-020 SHALL map byte lane n (n=0..3) to data bits 8n+7:8n, little-endian, lane = addr[1:0].
REQ-021 SHALL, for stores, write byte to lane addr[1:0], half to lanes addr[1]*2..+1, word to all lanes; unselected lanes unchanged.
REQ-022 SHALL, for loads, extract the addressed byte/half/word and extend to 32 bits per req_signed.
REQ-023 SHALL index words by addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (aliasing wrap-around).
REQ-024 SHALL treat req_size=11 as an error: no write, rsp_err=1, rsp_rdata=0.
REQ-025 SHALL hold rsp_rdata and rsp_err stable until the next response.

Reset
REQ-026 SHALL on rst: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 0 during the reset cycle.
REQ-027 SHALL leave memory contents unchanged by rst.
REQ-028 SHALL drop an in-flight access on rst; a store whose commit edge coincides with rst SHALL NOT be written.

Configuration
REQ-029 SHALL honour macro DMEM_ALIGN_TRAP_EN.
REQ-030 SHALL, with DMEM_ALIGN_TRAP_EN defined, reject half with addr[0]=1 and word with addr[1:0]!=0: no write, rsp_err=1, rsp_rdata=0, same latency.
REQ-031 SHALL, without DMEM_ALIGN_TRAP_EN, force alignment by clearing the offending low address bits and complete with rsp_err=0.

Structure
REQ-032 SHALL place size encodings, FSM state enum and lane-enable function in shared package dmem_pkg.
REQ-033 SHALL instantiate four copies of sub-module dmem_bank (byte-wide, DEPTH_WORDS deep, synchronous read, write enable), one per lane.

Verification
REQ-034 SHALL cover: WAIT_STATES=0, SW 0x11223344 @0x10, LW @0x10 -> rsp_valid in cycle 2 each, rdata 0x11223344, err 0.
REQ-035 SHALL cover: after REQ-034, SB 0xAB @0x12, LB signed @0x12 -> 0xFFFFFFAB; LBU @0x12 -> 0x000000AB; LW @0x10 -> 0x11AB3344.
REQ-036 SHALL cover: SH 0x8001 @0x16, LH signed @0x16 -> 0xFFFF8001; LH @0x15 -> err=1, no write (macro on); rdata 0x8001... from @0x14 (macro off).
REQ-037 SHALL cover: WAIT_STATES=3, back-to-back requests held valid -> accepts in cycles 0 and 5, responses in cycles 5 and 10, req_ready low in cycles 1-4.
REQ-038 SHALL cover: DEPTH_WORDS=1024, SW 0xDEADBEEF @0x1000 then LW @0x0 -> 0xDEADBEEF (wrap); req_size=11 -> err=1.
REQ-039 SHALL cover: rst asserted on the commit edge of SW 0x5 @0x20 -> no rsp_valid, subsequent LW @0x20 returns prior contents.
